// File: rtl/mem_access_stage.sv
// LC-3b MEM stage: EX/MEM payload latch, data-memory handshake (incl. LDI/STI), MEM/WB register.
// Optional watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_access_stage #(
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [2:0]        ex_memop,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [ADDR_W-1:0] ex_alu,
  input  logic [ADDR_W-1:0] ex_sdata,
  input  logic [2:0]        ex_dest,
  input  logic              ex_regwrite,
  input  logic [ADDR_W-1:0] dmem_rdata,
  input  logic              dmem_resp,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_wdata,
  output logic [1:0]        dmem_byte_en,
  output logic              stall,
  output logic [ADDR_W-1:0] exmem_alu,
  output logic [2:0]        exmem_dest,
  output logic              exmem_regwrite,
  output logic              wb_valid,
  output logic [ADDR_W-1:0] wb_data,
  output logic [2:0]        wb_dest,
  output logic              wb_regwrite,
  output logic              mem_error
);

  // state      | meaning
  // S_IDLE     | payload captured; ALU ops retire, memory ops dispatch
  // S_ACCESS   | single data access (LDR/LDB/STR/STB) awaiting dmem_resp
  // S_IND_PTR  | LDI/STI pointer read awaiting dmem_resp
  // S_IND_ACCESS | LDI/STI access through latched pointer
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_IND_PTR, S_IND_ACCESS} state_t;

  localparam logic [2:0] OP_LDR = 3'd1;
  localparam logic [2:0] OP_LDB = 3'd2;
  localparam logic [2:0] OP_STR = 3'd3;
  localparam logic [2:0] OP_STB = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_STI = 3'd6;

  state_t state, next_state;

  logic              p_valid;
  logic [2:0]        p_memop;
  logic [ADDR_W-1:0] p_addr;
  logic [ADDR_W-1:0] p_alu;
  logic [ADDR_W-1:0] p_sdata;
  logic [2:0]        p_dest;
  logic              p_regwrite;
  logic [ADDR_W-1:0] ptr;

  logic              is_mem, is_load, is_store, is_ind;
  logic              complete, ptr_load, timeout, advance;
  logic [7:0]        byte_sel;
  logic [ADDR_W-1:0] load_data;

  assign is_load  = (p_memop == OP_LDR) || (p_memop == OP_LDB) || (p_memop == OP_LDI);
  assign is_store = (p_memop == OP_STR) || (p_memop == OP_STB) || (p_memop == OP_STI);
  assign is_ind   = (p_memop == OP_LDI) || (p_memop == OP_STI);
  assign is_mem   = p_valid && (is_load || is_store);

  assign byte_sel  = p_addr[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];
  assign load_data = (p_memop == OP_LDB) ? {{(ADDR_W-8){byte_sel[7]}}, byte_sel} : dmem_rdata;

  always_comb begin
    next_state   = state;
    dmem_addr    = '0;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wdata   = '0;
    dmem_byte_en = 2'b00;
    complete     = 1'b0;
    ptr_load     = 1'b0;
    case (state)
      S_IDLE: begin
        if (is_mem) next_state = is_ind ? S_IND_PTR : S_ACCESS;
      end
      S_ACCESS: begin
        dmem_read  = is_load;
        dmem_write = is_store;
        if (p_memop == OP_LDB || p_memop == OP_STB) begin
          dmem_addr = p_addr;
        end else begin
          dmem_addr = {p_addr[ADDR_W-1:1], 1'b0};
        end
        if (p_memop == OP_STB) begin
          dmem_wdata   = {p_sdata[7:0], p_sdata[7:0]};
          dmem_byte_en = p_addr[0] ? 2'b10 : 2'b01;
        end else begin
          dmem_wdata   = p_sdata;
          dmem_byte_en = 2'b11;
        end
        if (dmem_resp) begin
          complete   = 1'b1;
          next_state = S_IDLE;
        end else if (timeout) begin
          next_state = S_IDLE;
        end
      end
      S_IND_PTR: begin
        dmem_read    = 1'b1;
        dmem_addr    = {p_addr[ADDR_W-1:1], 1'b0};
        dmem_byte_en = 2'b11;
        if (dmem_resp) begin
          ptr_load   = 1'b1;
          next_state = S_IND_ACCESS;
        end else if (timeout) begin
          next_state = S_IDLE;
        end
      end
      S_IND_ACCESS: begin
        dmem_read    = (p_memop == OP_LDI);
        dmem_write   = (p_memop == OP_STI);
        dmem_addr    = {ptr[ADDR_W-1:1], 1'b0};
        dmem_wdata   = p_sdata;
        dmem_byte_en = 2'b11;
        if (dmem_resp) begin
          complete   = 1'b1;
          next_state = S_IDLE;
        end else if (timeout) begin
          next_state = S_IDLE;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // Stall releases in the completion (or abort) cycle so upstream advances on the same edge.
  assign stall   = (state == S_IDLE) ? is_mem : !(complete || timeout);
  assign advance = ((state == S_IDLE) && !is_mem) || complete || timeout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_valid    <= 1'b0;
      p_memop    <= '0;
      p_addr     <= '0;
      p_alu      <= '0;
      p_sdata    <= '0;
      p_dest     <= '0;
      p_regwrite <= 1'b0;
    end else if (advance) begin
      p_valid    <= ex_valid;
      p_memop    <= ex_memop;
      p_addr     <= ex_addr;
      p_alu      <= ex_alu;
      p_sdata    <= ex_sdata;
      p_dest     <= ex_dest;
      p_regwrite <= ex_regwrite;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         ptr <= '0;
    else if (ptr_load) ptr <= dmem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid    <= 1'b0;
      wb_data     <= '0;
      wb_dest     <= '0;
      wb_regwrite <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if ((state == S_IDLE) && p_valid && !is_mem) begin
        wb_valid    <= 1'b1;
        wb_data     <= p_alu;
        wb_dest     <= p_dest;
        wb_regwrite <= p_regwrite;
      end else if (complete) begin
        wb_valid    <= 1'b1;
        wb_data     <= load_data;
        wb_dest     <= p_dest;
        wb_regwrite <= is_load && p_regwrite;
      end
    end
  end

  assign exmem_alu      = p_alu;
  assign exmem_dest     = p_dest;
  assign exmem_regwrite = p_regwrite && p_valid;

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] WD_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wd_cnt;
  logic       err_q;

  // Reloads on every state change, so each request phase gets the full window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt <= WD_LOAD;
      err_q  <= 1'b0;
    end else begin
      if (state == S_IDLE || state != next_state) wd_cnt <= WD_LOAD;
      else if (wd_cnt != 8'd0)                    wd_cnt <= wd_cnt - 8'd1;
      if (timeout) err_q <= 1'b1;
    end
  end

  assign timeout   = (state != S_IDLE) && !dmem_resp && (wd_cnt == 8'd0);
  assign mem_error = err_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = 1'b0;
  assign mem_error  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage; inputs driven and outputs sampled on negedge.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_memop;
  logic [15:0] ex_addr, ex_alu, ex_sdata;
  logic [2:0]  ex_dest;
  logic        ex_regwrite;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;
  logic [15:0] dmem_addr, dmem_wdata;
  logic        dmem_read, dmem_write;
  logic [1:0]  dmem_byte_en;
  logic        stall;
  logic [15:0] exmem_alu;
  logic [2:0]  exmem_dest;
  logic        exmem_regwrite;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        wb_regwrite;
  logic        mem_error;

  int errors = 0;
  int checks = 0;

  mem_access_stage #(.ADDR_W(16), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_memop(ex_memop), .ex_addr(ex_addr), .ex_alu(ex_alu),
    .ex_sdata(ex_sdata), .ex_dest(ex_dest), .ex_regwrite(ex_regwrite),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .dmem_addr(dmem_addr), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wdata(dmem_wdata), .dmem_byte_en(dmem_byte_en), .stall(stall),
    .exmem_alu(exmem_alu), .exmem_dest(exmem_dest), .exmem_regwrite(exmem_regwrite),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_dest(wb_dest), .wb_regwrite(wb_regwrite),
    .mem_error(mem_error)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic v, input logic [2:0] op, input logic [15:0] addr,
                       input logic [15:0] alu, input logic [15:0] sd, input logic [2:0] dst);
    ex_valid = v; ex_memop = op; ex_addr = addr; ex_alu = alu;
    ex_sdata = sd; ex_dest = dst; ex_regwrite = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1; dmem_resp = 1'b0; dmem_rdata = 16'h0;
    drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    repeat (2) @(negedge clk);
    checks++;
    if ({dmem_read, dmem_write, stall, wb_valid, wb_regwrite, exmem_regwrite, mem_error} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 0000000",
        {dmem_read, dmem_write, stall, wb_valid, wb_regwrite, exmem_regwrite, mem_error});
    end
    checks++;
    if ({dmem_addr, dmem_wdata, wb_data, exmem_alu} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h expected 0", {dmem_addr, dmem_wdata, wb_data, exmem_alu});
    end
    reset = 1'b0;
  endtask

  task automatic test_alu_op;
    @(negedge clk); drive(1'b1, 3'd0, 16'h0, 16'h1234, 16'h0, 3'd3);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    checks++;
    if ({exmem_alu, exmem_dest, exmem_regwrite, stall} !== {16'h1234, 3'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL alu_taps: got alu=%h dest=%0d rw=%b stall=%b expected 1234 3 1 0",
        exmem_alu, exmem_dest, exmem_regwrite, stall);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_data, wb_dest, wb_regwrite, stall} !== {1'b1, 16'h1234, 3'd3, 1'b1, 1'b0}) begin
      errors++; $display("FAIL alu_wb: got v=%b d=%h dst=%0d rw=%b stall=%b expected 1 1234 3 1 0",
        wb_valid, wb_data, wb_dest, wb_regwrite, stall);
    end
    checks++;
    if (exmem_regwrite !== 1'b0) begin
      errors++; $display("FAIL bubble_tap: got rw=%b expected 0", exmem_regwrite);
    end
    @(negedge clk);
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL alu_pulse: got wb_valid=%b expected 0", wb_valid);
    end
  endtask

  task automatic test_ldb;
    int stall_cnt = 0;
    @(negedge clk); drive(1'b1, 3'd2, 16'h3001, 16'h0, 16'h0, 3'd5);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    if (stall) stall_cnt++;
    @(negedge clk);
    if (stall) stall_cnt++;
    checks++;
    if ({dmem_read, dmem_write, dmem_addr, dmem_byte_en} !== {1'b1, 1'b0, 16'h3001, 2'b11}) begin
      errors++; $display("FAIL ldb_req: got r=%b w=%b a=%h be=%b expected 1 0 3001 11",
        dmem_read, dmem_write, dmem_addr, dmem_byte_en);
    end
    @(negedge clk);
    if (stall) stall_cnt++;
    @(negedge clk);
    dmem_resp = 1'b1; dmem_rdata = 16'h80FF; #1;
    if (stall) stall_cnt++;
    checks++;
    if (stall_cnt !== 3) begin
      errors++; $display("FAIL ldb_stall: got %0d stall cycles expected 3", stall_cnt);
    end
    @(negedge clk); dmem_resp = 1'b0;
    checks++;
    if ({wb_valid, wb_data, wb_dest, wb_regwrite, dmem_read} !== {1'b1, 16'hFF80, 3'd5, 1'b1, 1'b0}) begin
      errors++; $display("FAIL ldb_wb: got v=%b d=%h dst=%0d rw=%b rd=%b expected 1 ff80 5 1 0",
        wb_valid, wb_data, wb_dest, wb_regwrite, dmem_read);
    end
  endtask

  task automatic test_stb;
    @(negedge clk); drive(1'b1, 3'd4, 16'h4000, 16'h0, 16'hAB5C, 3'd1);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(negedge clk);
    checks++;
    if ({dmem_write, dmem_read, dmem_wdata, dmem_byte_en, dmem_addr} !== {1'b1, 1'b0, 16'h5C5C, 2'b01, 16'h4000}) begin
      errors++; $display("FAIL stb_req: got w=%b r=%b wd=%h be=%b a=%h expected 1 0 5c5c 01 4000",
        dmem_write, dmem_read, dmem_wdata, dmem_byte_en, dmem_addr);
    end
    dmem_resp = 1'b1;
    @(negedge clk); dmem_resp = 1'b0;
    checks++;
    if ({wb_valid, wb_regwrite} !== 2'b10) begin
      errors++; $display("FAIL stb_wb: got v=%b rw=%b expected 1 0", wb_valid, wb_regwrite);
    end
  endtask

  task automatic test_ldi;
    int pulses = 0;
    @(negedge clk); drive(1'b1, 3'd5, 16'h5000, 16'h0, 16'h0, 3'd2);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_addr} !== {1'b1, 16'h5000}) begin
      errors++; $display("FAIL ldi_ptr: got r=%b a=%h expected 1 5000", dmem_read, dmem_addr);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h6002; #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++; $display("FAIL ldi_ptr_stall: got %b expected 1", stall);
    end
    @(negedge clk); dmem_resp = 1'b0; dmem_rdata = 16'h0;
    if (wb_valid) pulses++;
    checks++;
    if ({dmem_read, dmem_addr} !== {1'b1, 16'h6002}) begin
      errors++; $display("FAIL ldi_acc: got r=%b a=%h expected 1 6002", dmem_read, dmem_addr);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'hBEEF;
    @(negedge clk); dmem_resp = 1'b0;
    if (wb_valid) pulses++;
    checks++;
    if ({wb_valid, wb_data, wb_dest} !== {1'b1, 16'hBEEF, 3'd2}) begin
      errors++; $display("FAIL ldi_wb: got v=%b d=%h dst=%0d expected 1 beef 2", wb_valid, wb_data, wb_dest);
    end
    repeat (2) begin
      @(negedge clk);
      if (wb_valid) pulses++;
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL ldi_pulses: got %0d expected 1", pulses);
    end
  endtask

  task automatic test_reset_mid_access;
    @(negedge clk); drive(1'b1, 3'd6, 16'h7000, 16'h0, 16'h1111, 3'd0);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(negedge clk);
    #2 reset = 1'b1; #1;
    checks++;
    if ({dmem_read, dmem_write, stall, dmem_addr, exmem_alu, wb_valid} !== 36'h0) begin
      errors++; $display("FAIL abort: got r=%b w=%b st=%b a=%h wb=%b expected all 0",
        dmem_read, dmem_write, stall, dmem_addr, wb_valid);
    end
    @(negedge clk); reset = 1'b0;
    drive(1'b1, 3'd6, 16'h7001, 16'h0, 16'h2222, 3'd0);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_addr} !== {1'b1, 16'h7000}) begin
      errors++; $display("FAIL sti_ptr: got r=%b a=%h expected 1 7000", dmem_read, dmem_addr);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h8003;
    @(negedge clk);
    checks++;
    if ({dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_byte_en} !== {1'b1, 1'b0, 16'h8002, 16'h2222, 2'b11}) begin
      errors++; $display("FAIL sti_acc: got w=%b r=%b a=%h wd=%h be=%b expected 1 0 8002 2222 11",
        dmem_write, dmem_read, dmem_addr, dmem_wdata, dmem_byte_en);
    end
    @(negedge clk); dmem_resp = 1'b0;
    checks++;
    if ({wb_valid, wb_regwrite} !== 2'b10) begin
      errors++; $display("FAIL sti_wb: got v=%b rw=%b expected 1 0", wb_valid, wb_regwrite);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk); drive(1'b1, 3'd0, 16'h0, 16'h1111, 16'h0, 3'd1);
    @(negedge clk); drive(1'b1, 3'd1, 16'h2001, 16'h0, 16'h0, 3'd4);
    @(negedge clk); drive(1'b1, 3'd0, 16'h0, 16'h2222, 16'h0, 3'd6);
    checks++;
    if ({wb_valid, wb_data, wb_dest, stall} !== {1'b1, 16'h1111, 3'd1, 1'b1}) begin
      errors++; $display("FAIL b2b_first: got v=%b d=%h dst=%0d st=%b expected 1 1111 1 1",
        wb_valid, wb_data, wb_dest, stall);
    end
    @(negedge clk);
    checks++;
    if ({dmem_read, dmem_addr, dmem_byte_en, wb_valid} !== {1'b1, 16'h2000, 2'b11, 1'b0}) begin
      errors++; $display("FAIL ldr_req: got r=%b a=%h be=%b wb=%b expected 1 2000 11 0",
        dmem_read, dmem_addr, dmem_byte_en, wb_valid);
    end
    dmem_resp = 1'b1; dmem_rdata = 16'h4321; #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL ldr_release: got stall=%b expected 0", stall);
    end
    @(negedge clk); dmem_resp = 1'b0; drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    checks++;
    if ({wb_valid, wb_data, wb_dest, exmem_alu} !== {1'b1, 16'h4321, 3'd4, 16'h2222}) begin
      errors++; $display("FAIL ldr_wb: got v=%b d=%h dst=%0d fwd=%h expected 1 4321 4 2222",
        wb_valid, wb_data, wb_dest, exmem_alu);
    end
    @(negedge clk);
    checks++;
    if ({wb_valid, wb_data, wb_dest} !== {1'b1, 16'h2222, 3'd6}) begin
      errors++; $display("FAIL b2b_last: got v=%b d=%h dst=%0d expected 1 2222 6", wb_valid, wb_data, wb_dest);
    end
  endtask

  task automatic test_idle_resp;
    @(negedge clk); dmem_resp = 1'b1; dmem_rdata = 16'hDEAD;
    @(negedge clk); dmem_resp = 1'b0;
    checks++;
    if ({wb_valid, stall, dmem_read, dmem_write} !== 4'b0) begin
      errors++; $display("FAIL idle_resp: got v=%b st=%b r=%b w=%b expected 0 0 0 0",
        wb_valid, stall, dmem_read, dmem_write);
    end
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout;
    int req_cnt = 0;
    @(negedge clk); drive(1'b1, 3'd1, 16'h0010, 16'h0, 16'h0, 3'd7);
    @(negedge clk); drive(1'b0, 3'd0, 16'h0, 16'h0, 16'h0, 3'd0);
    repeat (6) begin
      @(negedge clk);
      if (dmem_read) req_cnt++;
    end
    checks++;
    if (req_cnt !== 4) begin
      errors++; $display("FAIL wd_req_cycles: got %0d expected 4", req_cnt);
    end
    checks++;
    if ({mem_error, stall, wb_valid} !== 3'b100) begin
      errors++; $display("FAIL wd_state: got err=%b st=%b wb=%b expected 1 0 0", mem_error, stall, wb_valid);
    end
  endtask
`endif

  initial begin
    test_reset;
    test_alu_op;
    test_ldb;
    test_stb;
    test_ldi;
    test_reset_mid_access;
    test_back_to_back;
    test_idle_resp;
`ifdef MEM_TIMEOUT_EN
    test_timeout;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- LC-3b pipeline MEM stage, directly downstream of the execute stage.
- Latches the EX/MEM payload: ALU result, address, store data, dest, control bits.
- Runs the data-memory handshake for LDR/LDB/STR/STB and the two-access LDI/STI sequences, and stalls the pipe while memory is busy.
- Drives the MEM/WB register and the EX/MEM forwarding taps consumed by the forwarding unit.

Parameters:
- ADDR_W, 16, address and data width (lc3b_word).
- TIMEOUT_CYCLES, 64, watchdog limit; used only when MEM_TIMEOUT_EN is defined.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- ex_valid  in  1  EX/MEM payload valid this cycle.
- ex_memop  in  3  0 none, 1 LDR, 2 LDB, 3 STR, 4 STB, 5 LDI, 6 STI; 7 is treated as none.
- ex_addr  in  16  effective address (marmux output).
- ex_alu  in  16  ALU result for non-memory ops.
- ex_sdata  in  16  store data.
- ex_dest  in  3  destination register.
- ex_regwrite  in  1  instruction writes the register file.
- dmem_rdata  in  16  read data.
- dmem_resp  in  1  one-cycle memory completion.
- dmem_addr  out  16  memory address.
- dmem_read  out  1  read request.
- dmem_write  out  1  write request.
- dmem_wdata  out  16  write data.
- dmem_byte_en  out  2  byte lane enables, bit1 = high byte.
- stall  out  1  freeze upstream stages.
- exmem_alu  out  16  forwarding value (latched ex_alu).
- exmem_dest  out  3  forwarding destination.
- exmem_regwrite  out  1  forwarding write enable, valid-qualified.
- wb_valid  out  1  MEM/WB valid.
- wb_data  out  16  writeback data.
- wb_dest  out  3  writeback register.
- wb_regwrite  out  1  writeback enable.
- mem_error  out  1  sticky watchdog flag; tied 0 when the feature is absent.

Behaviour:
- Reset: every output is 0, state = IDLE, payload registers are cleared.
- Capture: in IDLE with stall low, the EX/MEM payload register loads all ex_* inputs on each rising clk edge. A bubble loads when ex_valid = 0.
- Forwarding taps come straight from the payload register. exmem_regwrite = latched regwrite AND latched valid.
- FSM states: IDLE, ACCESS, IND_PTR, IND_ACCESS.
  - IDLE with latched valid and memop none: wb_* load next cycle with data = latched alu. One-cycle stage latency.
  - IDLE with memop 1..4: go to ACCESS.
  - IDLE with memop 5/6: go to IND_PTR.
- IND_PTR: dmem_read = 1, dmem_addr = {addr[15:1],0}.
  - On dmem_resp, latch the pointer = dmem_rdata and go to IND_ACCESS.
- ACCESS / IND_ACCESS:
  - Address = latched addr, or the pointer in IND_ACCESS.
  - Request level is held until dmem_resp.
  - On dmem_resp: load wb_*, return to IDLE, and load the next payload on the same edge.
- Requests are level signals, held stable until resp. Read and write are never asserted together.
- stall is asserted combinationally in any non-IDLE state, and in IDLE when the latched op is a memory op. It deasserts in the cycle dmem_resp arrives.
- Width rules:
  - Word ops force addr bit0 = 0, byte_en = 11.
  - LDB: byte selected by addr[0] (1 = high), then sign-extended to 16 bits.
  - STB: wdata = {sdata[7:0], sdata[7:0]}, byte_en = addr[0] ? 10 : 01.
- Writeback:
  - Stores: wb_regwrite = 0, wb_valid = 1.
  - LDI: writeback data is the second read.
  - STI: writes ex_sdata to the pointer address.
- wb_valid pulses for exactly one cycle per completed instruction. During a stall, wb_valid = 0 (bubble).
- dmem_resp while in IDLE is ignored.
- Reset asserted mid-access aborts immediately to IDLE. No retry.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit watchdog counts cycles spent in a request state without dmem_resp.
  - At TIMEOUT_CYCLES the FSM drops the request and returns to IDLE.
  - A bubble is issued (wb_valid = 0).
  - mem_error sets and stays set until reset.
- Undefined: no counter; the stage waits indefinitely for dmem_resp; mem_error tied 0.

Test Plan:
- ALU op: ex_memop = 0, ex_alu = 0x1234, dest = 3, regwrite = 1 -> next cycle wb_valid = 1, wb_data = 0x1234, wb_dest = 3; stall never asserts.
- LDB: addr = 0x3001, rdata = 0x80FF, resp after 3 cycles -> dmem_addr = 0x3001, byte_en = 11, stall high for 3 cycles, wb_data = 0xFF80.
- STB: addr = 0x4000, sdata = 0xAB5C -> dmem_write = 1, wdata = 0x5C5C, byte_en = 01; wb_regwrite = 0.
- LDI: addr = 0x5000, first rdata = 0x6002, second rdata = 0xBEEF -> two reads at 0x5000 then 0x6002; wb_data = 0xBEEF; exactly one wb_valid pulse.
- Reset asserted in IND_PTR -> all outputs 0 the same cycle; the next instruction proceeds normally.
- MEM_TIMEOUT_EN with TIMEOUT_CYCLES = 4, no resp on LDR -> request drops after 4 cycles, mem_error = 1 and stays set, stall = 0.
